// File: rtl/tetris_driver.sv
// Stimulus initiator for the TETRIS engine: issues LFSR-generated pieces at legal
// columns, collects per-round scores and failures, and flags protocol or timeout errors.
module tetris_driver #(
  parameter int unsigned NUM_ROUNDS = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [15:0] SEED       = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        in_valid,
  output logic [2:0]  tetrominoes,
  output logic [2:0]  position,
  input  logic        tetris_valid,
  input  logic        score_valid,
  input  logic        fail,
  input  logic [3:0]  score,
  input  logic [71:0] tetris,
  output logic [71:0] last_board,
  output logic [7:0]  total_score,
  output logic [7:0]  fail_rounds,
  output logic [7:0]  rounds_done,
  output logic        err_timeout,
  output logic        err_proto
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_ROUND_END, S_DONE
  } state_e;

  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [4:0]        turn_cnt_q, turn_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]        score_cap_q, score_cap_d;
  logic              fail_cap_q, fail_cap_d;
  logic [71:0]       last_board_q, last_board_d;
  logic [7:0]        total_score_q, total_score_d;
  logic [7:0]        fail_rounds_q, fail_rounds_d;
  logic [7:0]        rounds_done_q, rounds_done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_proto_q, err_proto_d;

  logic [2:0] piece, raw, pos_max, pos_map;
  logic       lfsr_fb;
  logic [8:0] score_sum;
  logic       proto_viol;

  assign piece   = lfsr_q[2:0];
  assign raw     = lfsr_q[5:3];
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    case (piece)
      3'd0:    pos_max = 3'd4;
      3'd1:    pos_max = 3'd5;
      3'd2:    pos_max = 3'd2;
      3'd3:    pos_max = 3'd4;
      3'd4:    pos_max = 3'd3;
      3'd5:    pos_max = 3'd4;
      3'd6:    pos_max = 3'd4;
      default: pos_max = 3'd3;
    endcase
    pos_map = (raw > pos_max) ? (raw & pos_max) : raw;
  end

  assign in_valid    = (state_q == S_ISSUE);
  assign tetrominoes = in_valid ? piece : '0;
  assign position    = in_valid ? pos_map : '0;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                       (state_q == S_GAP)   || (state_q == S_ROUND_END);
  assign done        = (state_q == S_DONE);

  assign last_board  = last_board_q;
  assign total_score = total_score_q;
  assign fail_rounds = fail_rounds_q;
  assign rounds_done = rounds_done_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;

  assign proto_viol = (tetris_valid != score_valid) ||
                      (score_valid && (state_q != S_WAIT)) ||
                      (fail && !score_valid) ||
                      (score_valid && in_valid);

  assign score_sum = {1'b0, total_score_q} + (fail_cap_q ? 9'd0 : {5'd0, score_cap_q});

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    turn_cnt_d    = turn_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    score_cap_d   = score_cap_q;
    fail_cap_d    = fail_cap_q;
    last_board_d  = last_board_q;
    total_score_d = total_score_q;
    fail_rounds_d = fail_rounds_q;
    rounds_done_d = rounds_done_q;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q | proto_viol;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_d        = SEED_EFF;
          turn_cnt_d    = '0;
          score_cap_d   = '0;
          fail_cap_d    = 1'b0;
          last_board_d  = '0;
          total_score_d = '0;
          fail_rounds_d = '0;
          rounds_done_d = '0;
          err_timeout_d = 1'b0;
          err_proto_d   = proto_viol;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lfsr_d     = {lfsr_q[14:0], lfsr_fb};
        turn_cnt_d = turn_cnt_q + 5'd1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (score_valid) begin
          last_board_d = tetris;
          score_cap_d  = score;
          fail_cap_d   = fail;
          gap_cnt_d    = '0;
          state_d      = (fail || turn_cnt_q == 5'd16) ? S_ROUND_END : S_GAP;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 2)) begin
          // Issue cycle plus TIMEOUT-1 wait cycles: the response window spans TIMEOUT cycles.
          err_timeout_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_ROUND_END: begin
        rounds_done_d = (rounds_done_q == 8'hFF) ? 8'hFF : rounds_done_q + 8'd1;
        total_score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (fail_cap_q && fail_rounds_q != 8'hFF) begin
          fail_rounds_d = fail_rounds_q + 8'd1;
        end
        turn_cnt_d = '0;
        gap_cnt_d  = '0;
        state_d    = (rounds_done_d == 8'(NUM_ROUNDS)) ? S_DONE : S_GAP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 16'h0001;
      turn_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      score_cap_q   <= '0;
      fail_cap_q    <= 1'b0;
      last_board_q  <= '0;
      total_score_q <= '0;
      fail_rounds_q <= '0;
      rounds_done_q <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      turn_cnt_q    <= turn_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      score_cap_q   <= score_cap_d;
      fail_cap_q    <= fail_cap_d;
      last_board_q  <= last_board_d;
      total_score_q <= total_score_d;
      fail_rounds_q <= fail_rounds_d;
      rounds_done_q <= rounds_done_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

endmodule

// File: tb/tb_tetris_driver.sv
// Directed self-checking bench for tetris_driver: a scripted engine responder
// plus a second, unanswered instance for the timeout path.
module tb_tetris_driver;

  localparam logic [63:0] BOARD_TAG = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic        busy, done, in_valid;
  logic [2:0]  tetrominoes, position;
  logic        tetris_valid, score_valid, fail;
  logic [3:0]  score;
  logic [71:0] tetris, last_board;
  logic [7:0]  total_score, fail_rounds, rounds_done;
  logic        err_timeout, err_proto;

  logic        start2, busy2, done2, in_valid2;
  logic [2:0]  tet2, pos2;
  logic [71:0] lb2;
  logic [7:0]  ts2, fr2, rd2;
  logic        et2, ep2;

  logic        rsp_sv, rsp_fail, inj_sv, inj_tv;
  logic [3:0]  rsp_score;
  logic [71:0] rsp_board;
  bit          resp_en;
  int unsigned first_delay, fail_on, resp_n;
  logic [3:0]  resp_score_val;

  int unsigned n_assert = 0, n_fail = 0;
  int unsigned strobes, dones;
  logic [2:0]  p_type [3];
  logic [2:0]  p_pos  [3];

  assign score_valid  = rsp_sv | inj_sv;
  assign tetris_valid = rsp_sv | inj_tv;
  assign fail         = rsp_fail;
  assign score        = rsp_score;
  assign tetris       = rsp_board;

  tetris_driver #(.NUM_ROUNDS(4), .GAP_CYCLES(1), .TIMEOUT(16), .SEED(16'h0001)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .tetrominoes(tetrominoes), .position(position),
    .tetris_valid(tetris_valid), .score_valid(score_valid), .fail(fail),
    .score(score), .tetris(tetris), .last_board(last_board),
    .total_score(total_score), .fail_rounds(fail_rounds), .rounds_done(rounds_done),
    .err_timeout(err_timeout), .err_proto(err_proto)
  );

  tetris_driver #(.NUM_ROUNDS(1), .GAP_CYCLES(1), .TIMEOUT(16), .SEED(16'h002F)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .in_valid(in_valid2), .tetrominoes(tet2), .position(pos2),
    .tetris_valid(1'b0), .score_valid(1'b0), .fail(1'b0),
    .score(4'd0), .tetris(72'd0), .last_board(lb2),
    .total_score(ts2), .fail_rounds(fr2), .rounds_done(rd2),
    .err_timeout(et2), .err_proto(ep2)
  );

  function automatic logic [2:0] max_pos(input logic [2:0] t);
    case (t)
      3'd0: return 3'd4;
      3'd1: return 3'd5;
      3'd2: return 3'd2;
      3'd3: return 3'd4;
      3'd4: return 3'd3;
      3'd5: return 3'd4;
      3'd6: return 3'd4;
      default: return 3'd3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_strobe(input string tag, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (!in_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_strobe_seen"}, in_valid, 1'b1);
  endtask

  // Engine model: answers each strobe after a delay, scripted score/fail/board.
  initial begin
    int unsigned cnt;
    bit pend;
    cnt = 0; pend = 0;
    rsp_sv = 1'b0; rsp_fail = 1'b0; rsp_score = '0; rsp_board = '0;
    forever begin
      @(negedge clk);
      rsp_sv = 1'b0; rsp_fail = 1'b0; rsp_score = '0; rsp_board = '0;
      if (pend) begin
        if (!resp_en) pend = 0;
        else if (cnt > 1) cnt--;
        else begin
          pend = 0;
          resp_n++;
          rsp_sv    = 1'b1;
          rsp_fail  = (resp_n == fail_on);
          rsp_score = resp_score_val;
          rsp_board = {8'(resp_n), BOARD_TAG};
        end
      end
      if (resp_en && in_valid) begin
        pend = 1;
        cnt  = (resp_n == 0) ? first_delay : 1;
      end
    end
  end

  // Strobe monitor: legality of every piece, zeroed fields when idle, pulse counts.
  initial begin
    forever begin
      @(negedge clk);
      if (in_valid) begin
        if (strobes < 3) begin
          p_type[strobes] = tetrominoes;
          p_pos[strobes]  = position;
        end
        strobes++;
        check("pos_legal", position <= max_pos(tetrominoes), 1'b1);
      end else begin
        check("idle_fields_zero", {tetrominoes, position}, 6'd0);
      end
      if (done) dones++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed time limit expired, required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned done_at, extra, k;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; inj_sv = 1'b0; inj_tv = 1'b0;
    resp_en = 0; first_delay = 1; fail_on = 0; resp_score_val = '0; resp_n = 0;
    strobes = 0; dones = 0;
    tick(3);
    check("rst_ctrl", {busy, done, in_valid, tetrominoes, position, err_timeout, err_proto}, '0);
    check("rst_counters", {total_score, fail_rounds, rounds_done}, '0);
    check("rst_board", last_board, '0);
    check("rst_dut2", {busy2, done2, in_valid2, rd2, ts2, fr2, et2, ep2, lb2}, '0);
    rst = 1'b0;
    tick(1);

    // Unanswered instance, SEED 0x002F: first piece (7,1), then timeout.
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    check("seed2f_strobe", in_valid2, 1'b1);
    check("seed2f_busy", busy2, 1'b1);
    check("seed2f_piece", {tet2, pos2}, {3'd7, 3'd1});
    done_at = 0; extra = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done2 && done_at == 0) done_at = i;
      if (in_valid2) extra++;
    end
    check("timeout_done_cycle", done_at, 16);
    check("timeout_no_second_strobe", extra, 0);
    check("timeout_err", et2, 1'b1);
    check("timeout_state", {busy2, rd2, ep2}, '0);

    // Fail on 3rd response of round 1; first response arrives on the last legal cycle.
    resp_en = 1; first_delay = 15; fail_on = 3; resp_score_val = 4'd5; resp_n = 0;
    strobes = 0; dones = 0;
    pulse_start;
    check("fail_busy", busy, 1'b1);
    wait_done("fail_run", 3000);
    check("fail_busy_at_done", busy, 1'b0);
    check("fail_rounds_done", rounds_done, 8'd4);
    check("fail_fail_rounds", fail_rounds, 8'd1);
    check("fail_total_score", total_score, 8'd15);
    check("fail_strobes", strobes, 51);
    check("fail_errs", {err_timeout, err_proto}, 2'b00);
    check("fail_last_board", last_board, {8'd51, BOARD_TAG});
    tick(1);
    check("fail_done_once", {done, 8'(dones)}, {1'b0, 8'd1});

    // Protocol: lone tetris_valid while idle, then unsolicited score_valid in GAP.
    resp_en = 0;
    inj_tv = 1'b1;
    tick(1);
    inj_tv = 1'b0;
    tick(1);
    check("proto_tv_mismatch", err_proto, 1'b1);
    tick(3);
    check("proto_sticky", err_proto, 1'b1);
    resp_en = 1; first_delay = 1; fail_on = 0; resp_score_val = '0; resp_n = 0;
    strobes = 0; dones = 0;
    pulse_start;
    check("proto_cleared_by_start", err_proto, 1'b0);
    tick(2);
    inj_sv = 1'b1; inj_tv = 1'b1;
    tick(1);
    inj_sv = 1'b0; inj_tv = 1'b0;
    check("proto_sv_in_gap", err_proto, 1'b1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_start_busy", busy, 1'b1);
    wait_done("proto_run", 3000);
    check("proto_rounds_done", rounds_done, 8'd4);
    check("proto_strobes", strobes, 64);
    check("proto_err_held", {err_proto, err_timeout}, 2'b10);

    // Reset while waiting for a response in round 2.
    resp_n = 0; strobes = 0; dones = 0;
    tick(1);
    pulse_start;
    k = 0;
    while (rounds_done != 8'd1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_round1", rounds_done, 8'd1);
    wait_strobe("rst_mid", 20);
    resp_en = 0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_ctrl", {busy, done, in_valid, err_timeout, err_proto}, '0);
    check("rst_mid_counters", {total_score, fail_rounds, rounds_done}, '0);
    check("rst_mid_board", last_board, '0);

    // Clean session: zero scores, SEED 0x0001.
    resp_en = 1; first_delay = 1; fail_on = 0; resp_score_val = '0; resp_n = 0;
    strobes = 0; dones = 0;
    tick(1);
    pulse_start;
    check("clean_busy", busy, 1'b1);
    wait_done("clean_run", 3000);
    check("clean_busy_at_done", busy, 1'b0);
    check("clean_piece0", {p_type[0], p_pos[0]}, {3'd1, 3'd0});
    check("clean_piece1", {p_type[1], p_pos[1]}, {3'd2, 3'd0});
    check("clean_piece2", {p_type[2], p_pos[2]}, {3'd4, 3'd0});
    check("clean_strobes", strobes, 64);
    check("clean_counters", {rounds_done, total_score, fail_rounds}, {8'd4, 8'd0, 8'd0});
    check("clean_errs", {err_timeout, err_proto}, 2'b00);
    check("clean_last_board", last_board, {8'd64, BOARD_TAG});
    tick(1);
    check("clean_done_once", {done, busy, 8'(dones)}, {1'b0, 1'b0, 8'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
